init_memory_fsm: RTL and testbench



---
 rtl/rc4_pkg.sv | 13 +
 rtl/addr_counter.sv | 39 +++
 rtl/init_memory_fsm.sv | 103 ++++++++++
 tb/tb_init_memory_fsm.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared S-memory constants and init-stage state type
package rc4_pkg;

    localparam int S_ADDR_WIDTH = 8;
    localparam int S_DEPTH      = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } init_state_t;

endpackage

// File: rtl/addr_counter.sv
// rtl/addr_counter.sv - ADDR_WIDTH-bit up-counter with clear, enable and all-ones flag
module addr_counter #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  enable,
    output logic [ADDR_WIDTH-1:0] count,
    output logic                  last
);

    logic [ADDR_WIDTH-1:0] count_q;
    logic [ADDR_WIDTH-1:0] count_d;

    // Clear wins over enable so a restart always begins at address 0.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register; reset returns it to 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    // All-ones detect lets the counter stay exactly ADDR_WIDTH bits wide.
    assign last  = &count_q;

endmodule

// File: rtl/init_memory_fsm.sv
// rtl/init_memory_fsm.sv - fills S-memory with the identity permutation on request
module init_memory_fsm
    import rc4_pkg::*;
#(
    parameter int ADDR_WIDTH = S_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    output logic                  finish,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [ADDR_WIDTH-1:0] data,
    output logic                  wren
);

    init_state_t           state_q;
    init_state_t           state_d;
    logic                  wren_q;
    logic                  wren_d;
    logic                  finish_q;
    logic                  finish_d;
    logic                  cnt_clr;
    logic                  cnt_en;
    logic                  cnt_last;
    logic [ADDR_WIDTH-1:0] cnt_value;

    addr_counter #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_counter (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clr),
        .enable (cnt_en),
        .count  (cnt_value),
        .last   (cnt_last)
    );

    // Next-state and registered-output decode; counter holds on the final write.
    always_comb begin
        state_d  = state_q;
        wren_d   = wren_q;
        finish_d = finish_q;
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                wren_d   = 1'b0;
                finish_d = 1'b0;
                if (start) begin
                    state_d = WRITE;
                    wren_d  = 1'b1;
                    cnt_clr = 1'b1;
                end
            end
            WRITE: begin
                wren_d   = 1'b1;
                finish_d = 1'b0;
                if (cnt_last) begin
                    state_d  = DONE;
                    wren_d   = 1'b0;
                    finish_d = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE: begin
                wren_d   = 1'b0;
                finish_d = 1'b1;
                if (!start) begin
                    state_d  = IDLE;
                    finish_d = 1'b0;
                    cnt_clr  = 1'b1;
                end
            end
            default: begin
                state_d  = IDLE;
                wren_d   = 1'b0;
                finish_d = 1'b0;
                cnt_clr  = 1'b1;
            end
        endcase
    end

    // State and output registers; reset takes priority over every transition.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            wren_q   <= 1'b0;
            finish_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wren_q   <= wren_d;
            finish_q <= finish_d;
        end
    end

    assign finish  = finish_q;
    assign wren    = wren_q;
    assign address = cnt_value;
    // Identity permutation: write data is the address itself.
    assign data    = cnt_value;

endmodule

// File: tb/tb_init_memory_fsm.sv
// tb/tb_init_memory_fsm.sv - self-checking bench for init_memory_fsm
module tb_init_memory_fsm;

    logic       clock;
    logic       reset8, start8, finish8, wren8;
    logic [7:0] addr8, data8;
    logic       reset4, start4, finish4, wren4;
    logic [3:0] addr4, data4;

    int checks = 0;
    int errors = 0;
    int mem [256];

    typedef struct {
        logic       rst;
        logic       st;
        logic       exp_wren;
        logic       exp_fin;
        logic [3:0] exp_addr;
    } vec_t;

    vec_t vecs [$];

    init_memory_fsm #(.ADDR_WIDTH(8)) dut8 (
        .clock   (clock),
        .reset   (reset8),
        .start   (start8),
        .finish  (finish8),
        .address (addr8),
        .data    (data8),
        .wren    (wren8)
    );

    init_memory_fsm #(.ADDR_WIDTH(4)) dut4 (
        .clock   (clock),
        .reset   (reset4),
        .start   (start4),
        .finish  (finish4),
        .address (addr4),
        .data    (data4),
        .wren    (wren4)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Runs from the cycle after E0 until finish rises; counts writes and sequence faults.
    task automatic run_fill(output int nw, output int bad);
        int exp_a;
        nw    = 0;
        bad   = 0;
        exp_a = 0;
        for (int c = 0; c < 600; c++) begin
            if (wren8) begin
                if (int'(addr8) != exp_a || int'(data8) != exp_a) bad++;
                mem[addr8] = int'(data8);
                nw++;
                exp_a++;
            end
            if (wren8 && finish8) bad++;
            if (finish8) break;
            step();
        end
    endtask

    vec_t v;
    int   nw, bad, merr, nw2, bad2, guard;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = -1;
        reset8 = 1'b1; start8 = 1'b0;
        reset4 = 1'b1; start4 = 1'b0;

        // Reset state
        step(); step();
        chk("rst_wren", wren8, 0);
        chk("rst_finish", finish8, 0);
        chk("rst_addr", addr8, 0);
        chk("rst_data", data8, 0);
        reset8 = 1'b0;

        // Basic fill with start held high
        start8 = 1'b1;
        step();
        chk("e0_wren", wren8, 1);
        chk("e0_addr", addr8, 0);
        run_fill(nw, bad);
        chk("fill_writes", nw, 256);
        chk("fill_seq", bad, 0);
        chk("fill_finish", finish8, 1);
        chk("fill_wren_off", wren8, 0);
        chk("fill_addr_hold", addr8, 255);
        merr = 0;
        for (int i = 0; i < 256; i++) if (mem[i] != i) merr++;
        chk("mem_identity", merr, 0);

        // Handshake release: start held 10 more cycles
        merr = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (finish8 !== 1'b1 || wren8 !== 1'b0) merr++;
        end
        chk("hold_done", merr, 0);
        start8 = 1'b0;
        step();
        chk("release_finish", finish8, 0);
        chk("release_addr", addr8, 0);
        chk("release_wren", wren8, 0);

        // Early start drop: one-cycle pulse
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        chk("pulse_e0_wren", wren8, 1);
        run_fill(nw, bad);
        chk("pulse_writes", nw, 256);
        chk("pulse_seq", bad, 0);
        chk("pulse_finish", finish8, 1);
        step();
        chk("pulse_done_1cyc", finish8, 0);

        // Reset mid-fill at address 100
        start8 = 1'b1;
        step();
        guard = 0;
        while (addr8 != 8'd100 && guard < 300) begin
            step();
            guard++;
        end
        chk("reach_100", addr8, 100);
        chk("reach_100_wren", wren8, 1);
        reset8 = 1'b1;
        step();
        reset8 = 1'b0;
        chk("midrst_wren", wren8, 0);
        chk("midrst_addr", addr8, 0);
        chk("midrst_finish", finish8, 0);
        step();
        chk("refill_wren", wren8, 1);
        chk("refill_addr", addr8, 0);
        run_fill(nw, bad);
        chk("refill_writes", nw, 256);
        chk("refill_seq", bad, 0);
        start8 = 1'b0;
        step();

        // Back-to-back runs
        start8 = 1'b1;
        step();
        run_fill(nw, bad);
        start8 = 1'b0;
        step();
        start8 = 1'b1;
        step();
        run_fill(nw2, bad2);
        chk("b2b_writes_1", nw, 256);
        chk("b2b_writes_2", nw2, 256);
        chk("b2b_seq", bad + bad2, 0);
        start8 = 1'b0;
        step();
        chk("b2b_idle", finish8, 0);

        // ADDR_WIDTH=4 vector table
        v = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0};  vecs.push_back(v);
        v = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0};  vecs.push_back(v);
        for (int i = 1; i < 16; i++) begin
            v = '{1'b0, 1'b0, 1'b1, 1'b0, 4'(i)}; vecs.push_back(v);
        end
        v = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd15}; vecs.push_back(v);
        v = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0};  vecs.push_back(v);
        v = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0};  vecs.push_back(v);
        for (int i = 1; i < 16; i++) begin
            v = '{1'b0, 1'b1, 1'b1, 1'b0, 4'(i)}; vecs.push_back(v);
        end
        v = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd15}; vecs.push_back(v);
        v = '{1'b0, 1'b1, 1'b0, 1'b1, 4'd15}; vecs.push_back(v);
        v = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0};  vecs.push_back(v);
        v = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0};  vecs.push_back(v);
        v = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd1};  vecs.push_back(v);
        v = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd0};  vecs.push_back(v);
        v = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0};  vecs.push_back(v);
        v = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0};  vecs.push_back(v);

        for (int i = 0; i < vecs.size(); i++) begin
            reset4 = vecs[i].rst;
            start4 = vecs[i].st;
            step();
            chk($sformatf("w4_wren[%0d]", i), wren4, vecs[i].exp_wren);
            chk($sformatf("w4_finish[%0d]", i), finish4, vecs[i].exp_fin);
            chk($sformatf("w4_addr[%0d]", i), addr4, vecs[i].exp_addr);
            chk($sformatf("w4_data[%0d]", i), data4, vecs[i].exp_addr);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
